input_mems: RTL and testbench
=============================

// Module: input_mems
// PURPOSE
// Matrix-vector multiply engine with AXI-Stream-style input and output ports.
// It stores an MxN weight matrix and an N-element input vector from one input stream, then computes y = W*x.
// It streams the M results out one word per beat.
// Sits between a host stream source and the downstream result consumer.
// PARAMETERS
// INW   16  data width of input words, stored elements and outputs (signed)
// M     4   matrix rows = number of output words per result
// N     4   matrix columns = vector length
// LOGN  $clog2(N) (local)   LOGMN $clog2(M*N) (local, matrix write counter)
// PORTS
// clk            in   1        single clock, rising edge
// reset          in   1        asynchronous, active-low reset
// INPUT_TDATA    in   INW      input word (matrix or vector element)
// INPUT_TVALID   in   1        input word valid
// INPUT_TLAST    in   1        last word of input packet
// INPUT_TUSER    in   LOGN+1   [0]=new_matrix flag; [LOGN:1]=vector element index
// INPUT_TREADY   out  1        block can accept input
// OUTPUT_TDATA   out  INW      result word y[i]
// OUTPUT_TVALID  out  1        result word valid
// OUTPUT_TREADY  in   1        consumer accepts result
// BEHAVIOUR
// - Beat transfers on a rising clk edge when VALID and READY are both 1.
// - Reset: outputs go to 0. State goes to LOAD. Matrix and vector RAMs clear to 0. new_matrix flag clears.
// - Reset is honoured in any state; an in-flight packet or result is discarded.
// - States: LOAD -> COMPUTE -> OUTPUT -> LOAD.
// - LOAD: INPUT_TREADY=1. The first beat of each packet latches new_matrix=INPUT_TUSER[0]. TUSER[0] is ignored on later beats.
// - If new_matrix=1, the first M*N beats write W row-major via a counter: beat k -> W[k/N][k%N].
// - All following beats, and every beat when new_matrix=0, write x[TUSER[LOGN:1]] = TDATA.
// - A beat with TLAST=1 completes its write and moves to COMPUTE. Elements not written keep their old values.
// - With new_matrix=0, the previously stored W is reused; after reset that W is all zero.
// - COMPUTE: INPUT_TREADY=0. M parallel MACs run for exactly N cycles; cycle j adds W[i][j]*x[j] to acc[i].
// - Accumulators clear on entering COMPUTE.
// - Arithmetic: signed products; accumulate and truncate modulo 2^INW. No saturation and no overflow flag.
// - OUTPUT: OUTPUT_TVALID=1 and OUTPUT_TDATA=acc[i], starting at i=0.
// - i advances on each output handshake; the result stays stable while OUTPUT_TREADY=0.
// - After the handshake of y[M-1], OUTPUT_TVALID drops the next cycle and the block returns to LOAD (INPUT_TREADY=1).
// - Latency: first OUTPUT_TVALID rises N+1 clk edges after the TLAST handshake edge.
// - With OUTPUT_TREADY held at 1, the M results appear on consecutive cycles.
// - INPUT_TVALID=0 in LOAD: no writes, counters hold. Input is never accepted in COMPUTE or OUTPUT.
// TESTING
// - Matrix load then multiply:
//     stimulus: new_matrix packet with W=1..16 row-major, then x=[1,2,3,4] at TUSER idx 0..3, TLAST on x[3]
//     response: outputs 30,70,110,150
// - Matrix reuse:
//     stimulus: new_matrix=0 packet with x=[2,2,2,2]
//     response: outputs 20,52,84,116; W is unchanged
// - Output backpressure:
//     stimulus: OUTPUT_TREADY=0 for 5 cycles after TVALID rises
//     response: y[0]=30 is held stable, no result is skipped, INPUT_TREADY stays 0
// - Signed wrap:
//     stimulus: W row0=[0x7FFF,0x7FFF,0,0], x=[1,1,0,0]
//     response: y[0]=0xFFFE (modulo 2^16); W row1=[-3,0,0,0], x[0]=1 gives y[1]=0xFFFD
// - Reset mid-operation:
//     stimulus: assert reset during OUTPUT after y[1]
//     response: TVALID=0 at once, INPUT_TREADY=1 after release, a reuse packet yields all zeros
// - Out-of-order vector:
//     stimulus: x indices sent as 3,1,0,2 with W=1..16
//     response: results identical to in-order delivery

Source files
------------

// File: rtl/input_mems.sv
// Matrix-vector engine: loads W (MxN) and x (N) from one input stream, computes y = W*x, streams M results.
// Latency: first result N+1 cycles after TLAST; input stalls (TREADY=0) during compute and result drain.
module input_mems #(
    parameter int INW = 16,
    parameter int M   = 4,
    parameter int N   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INW-1:0]        INPUT_TDATA,
    input  logic                  INPUT_TVALID,
    input  logic                  INPUT_TLAST,
    input  logic [$clog2(N):0]    INPUT_TUSER,
    output logic                  INPUT_TREADY,
    output logic [INW-1:0]        OUTPUT_TDATA,
    output logic                  OUTPUT_TVALID,
    input  logic                  OUTPUT_TREADY
);
    localparam int LOGN  = $clog2(N);
    localparam int LOGM  = $clog2(M);
    localparam int LOGMN = $clog2(M * N);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

    state_t               r_state;
    logic [INW-1:0]       r_w   [M][N];
    logic [INW-1:0]       r_x   [N];
    logic [INW-1:0]       r_acc [M];
    logic                 r_first;
    logic                 r_nm;
    logic [LOGMN:0]       r_wcnt;
    logic [LOGN:0]        r_j;
    logic [LOGM-1:0]      r_oidx;
    logic                 r_in_rdy;
    logic                 r_out_vld;
    logic [INW-1:0]       r_out_dat;

    logic                 w_nm;
    logic                 w_wr_mat;
    logic [2*INW-1:0]     w_prod [M];

    assign INPUT_TREADY  = r_in_rdy;
    assign OUTPUT_TVALID = r_out_vld;
    assign OUTPUT_TDATA  = r_out_dat;

    // The new_matrix flag only counts on the first beat of a packet.
    assign w_nm     = r_first ? INPUT_TUSER[0] : r_nm;
    assign w_wr_mat = w_nm && (r_wcnt < (LOGMN+1)'(M * N));

    always_comb begin
        for (int i = 0; i < M; i++) begin
            w_prod[i] = '0;
            w_prod[i] = $signed(r_w[i][r_j[LOGN-1:0]]) * $signed(r_x[r_j[LOGN-1:0]]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_LOAD;
            r_first   <= 1'b1;
            r_nm      <= 1'b0;
            r_wcnt    <= '0;
            r_j       <= '0;
            r_oidx    <= '0;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            for (int i = 0; i < M; i++) begin
                r_acc[i] <= '0;
                for (int j = 0; j < N; j++) r_w[i][j] <= '0;
            end
            for (int j = 0; j < N; j++) r_x[j] <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (INPUT_TVALID && r_in_rdy) begin
                        if (r_first) r_nm <= INPUT_TUSER[0];
                        if (w_wr_mat) begin
                            r_w[r_wcnt[LOGMN-1:LOGN]][r_wcnt[LOGN-1:0]] <= INPUT_TDATA;
                            r_wcnt <= r_wcnt + 1'b1;
                        end else begin
                            r_x[INPUT_TUSER[LOGN:1]] <= INPUT_TDATA;
                        end
                        if (INPUT_TLAST) begin
                            r_state  <= S_COMPUTE;
                            r_in_rdy <= 1'b0;
                            r_first  <= 1'b1;
                            r_wcnt   <= '0;
                            r_j      <= '0;
                            for (int i = 0; i < M; i++) r_acc[i] <= '0;
                        end else begin
                            r_first <= 1'b0;
                        end
                    end
                end
                S_COMPUTE: begin
                    // N MAC cycles, then one cycle to present y[0].
                    if (r_j == (LOGN+1)'(N)) begin
                        r_state   <= S_OUTPUT;
                        r_out_vld <= 1'b1;
                        r_out_dat <= r_acc[0];
                        r_oidx    <= '0;
                    end else begin
                        for (int i = 0; i < M; i++)
                            r_acc[i] <= r_acc[i] + w_prod[i][INW-1:0];
                        r_j <= r_j + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (OUTPUT_TREADY) begin
                        if (r_oidx == LOGM'(M - 1)) begin
                            r_out_vld <= 1'b0;
                            r_out_dat <= '0;
                            r_state   <= S_LOAD;
                            r_in_rdy  <= 1'b1;
                        end else begin
                            r_oidx    <= r_oidx + 1'b1;
                            r_out_dat <= r_acc[r_oidx + 1'b1];
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_input_mems.sv
// Bench for input_mems: directed vector table plus randomized packets checked against an array model of W and x.
module tb_input_mems;
    localparam int INW = 16;
    localparam int M   = 4;
    localparam int N   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [INW-1:0]  INPUT_TDATA = '0;
    logic            INPUT_TVALID = 1'b0;
    logic            INPUT_TLAST = 1'b0;
    logic [2:0]      INPUT_TUSER = '0;
    logic            INPUT_TREADY;
    logic [INW-1:0]  OUTPUT_TDATA;
    logic            OUTPUT_TVALID;
    logic            OUTPUT_TREADY = 1'b1;

    input_mems #(.INW(INW), .M(M), .N(N)) dut (
        .clk(clk), .reset(reset),
        .INPUT_TDATA(INPUT_TDATA), .INPUT_TVALID(INPUT_TVALID), .INPUT_TLAST(INPUT_TLAST),
        .INPUT_TUSER(INPUT_TUSER), .INPUT_TREADY(INPUT_TREADY),
        .OUTPUT_TDATA(OUTPUT_TDATA), .OUTPUT_TVALID(OUTPUT_TVALID), .OUTPUT_TREADY(OUTPUT_TREADY)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] mw [M][N];
    logic [15:0] mx [N];

    typedef struct packed {
        logic              nm;
        logic [15:0][15:0] w;
        logic [3:0][15:0]  x;
        logic [3:0][1:0]   ord;
        int                stall;
        logic [3:0][15:0]  exp;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) mw[i][j] = '0;
        for (int j = 0; j < N; j++) mx[j] = '0;
    endfunction

    function automatic logic [3:0][15:0] model_y();
        logic [3:0][15:0] y;
        for (int i = 0; i < M; i++) begin
            int s = 0;
            for (int j = 0; j < N; j++)
                s = s + int'($signed(mw[i][j])) * int'($signed(mx[j]));
            y[i] = s[15:0];
        end
        return y;
    endfunction

    task automatic send(input logic nm, input logic [15:0][15:0] w, input logic [3:0][15:0] x,
                        input logic [3:0][1:0] ord, input int nx, input bit gaps);
        int nbeats = (nm ? 16 : 0) + nx;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    INPUT_TVALID = 1'b0;
                    @(negedge clk);
                end
            end
            check("in_rdy_load", {31'd0, INPUT_TREADY}, 32'd1);
            INPUT_TVALID = 1'b1;
            INPUT_TLAST  = (b == nbeats - 1);
            if (nm && b < 16) begin
                INPUT_TDATA = w[b];
                INPUT_TUSER = {2'($urandom_range(0, 3)), (b == 0) ? nm : ~nm};
                mw[b / N][b % N] = w[b];
            end else begin
                logic [1:0] idx;
                idx = ord[b - (nm ? 16 : 0)];
                INPUT_TDATA = x[idx];
                INPUT_TUSER = {idx, (b == 0) ? nm : ~nm};
                mx[idx] = x[idx];
            end
        end
        @(negedge clk);
        INPUT_TVALID = 1'b0;
        INPUT_TLAST  = 1'b0;
    endtask

    task automatic recv(input logic [3:0][15:0] exp, input int nget, input int stall,
                        input bit rnd, input string name);
        int got = 0;
        int cyc = 0;
        int vcyc = 0;
        bit seen = 0;
        bit held = 0;
        logic [15:0] hd = '0;
        while (got < nget && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (OUTPUT_TVALID && !seen) begin
                seen = 1;
                check({name, " latency"}, cyc, N + 1);
            end
            if (held) check({name, " held"}, {15'd0, OUTPUT_TVALID, OUTPUT_TDATA}, {16'd1, hd});
            OUTPUT_TREADY = (OUTPUT_TVALID && vcyc < stall) ? 1'b0 :
                            (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            held = 0;
            if (OUTPUT_TVALID) begin
                vcyc++;
                check({name, " in_rdy_busy"}, {31'd0, INPUT_TREADY}, 32'd0);
                if (OUTPUT_TREADY) begin
                    check($sformatf("%s y%0d", name, got), {16'd0, OUTPUT_TDATA}, {16'd0, exp[got]});
                    got++;
                end else begin
                    held = 1;
                    hd = OUTPUT_TDATA;
                end
            end
        end
        if (got < nget) check({name, " timeout"}, got, nget);
        if (nget == M) begin
            @(negedge clk);
            check({name, " vld_drop"}, {31'd0, OUTPUT_TVALID}, 32'd0);
            check({name, " in_rdy_back"}, {31'd0, INPUT_TREADY}, 32'd1);
        end
        OUTPUT_TREADY = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][15:0] ramp;
        logic [3:0][1:0]   inord;
        logic [15:0][15:0] rw;
        logic [3:0][15:0]  rx;
        logic [3:0][1:0]   rord;
        logic              rnm;
        int                rnx;

        for (int k = 0; k < 16; k++) ramp[k] = 16'(k + 1);
        for (int k = 0; k < 4; k++) inord[k] = 2'(k);

        tbl[0] = '0; tbl[0].nm = 1; tbl[0].w = ramp; tbl[0].ord = inord;
        for (int k = 0; k < 4; k++) tbl[0].x[k] = 16'(k + 1);
        tbl[0].exp[0] = 30; tbl[0].exp[1] = 70; tbl[0].exp[2] = 110; tbl[0].exp[3] = 150;

        tbl[1] = '0; tbl[1].nm = 0; tbl[1].ord = inord;
        for (int k = 0; k < 4; k++) tbl[1].x[k] = 16'd2;
        tbl[1].exp[0] = 20; tbl[1].exp[1] = 52; tbl[1].exp[2] = 84; tbl[1].exp[3] = 116;

        tbl[2] = tbl[0]; tbl[2].nm = 0; tbl[2].stall = 5;

        tbl[3] = tbl[0];
        tbl[3].ord[0] = 3; tbl[3].ord[1] = 1; tbl[3].ord[2] = 0; tbl[3].ord[3] = 2;

        tbl[4] = '0; tbl[4].nm = 1; tbl[4].ord = inord;
        tbl[4].w[0] = 16'h7FFF; tbl[4].w[1] = 16'h7FFF; tbl[4].w[4] = 16'hFFFD;
        tbl[4].x[0] = 1; tbl[4].x[1] = 1;
        tbl[4].exp[0] = 16'hFFFE; tbl[4].exp[1] = 16'hFFFD;

        model_clear();
        #12;
        check("reset tvalid", {31'd0, OUTPUT_TVALID}, 32'd0);
        check("reset tdata", {16'd0, OUTPUT_TDATA}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset in_rdy", {31'd0, INPUT_TREADY}, 32'd1);

        for (int t = 0; t < 5; t++) begin
            send(tbl[t].nm, tbl[t].w, tbl[t].x, tbl[t].ord, 4, 1'b0);
            recv(tbl[t].exp, M, tbl[t].stall, 1'b0, $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 12; r++) begin
            rnm = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) rw[k] = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                rx[k] = 16'($urandom);
                rord[k] = 2'($urandom_range(0, 3));
            end
            rnx = $urandom_range(1, 4);
            send(rnm, rw, rx, rord, rnx, 1'b1);
            recv(model_y(), M, 0, 1'b1, $sformatf("rnd%0d", r));
        end

        send(1'b0, tbl[0].w, tbl[0].x, inord, 4, 1'b0);
        recv(model_y(), 2, 0, 1'b0, "mid_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_reset tvalid", {31'd0, OUTPUT_TVALID}, 32'd0);
        check("mid_reset tdata", {16'd0, OUTPUT_TDATA}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        check("post_reset in_rdy", {31'd0, INPUT_TREADY}, 32'd1);
        for (int k = 0; k < 4; k++) rx[k] = 16'(k + 5);
        send(1'b0, tbl[0].w, rx, inord, 4, 1'b0);
        recv('0, M, 0, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
